// File: rtl/clk_gate_ctrl.sv
// Sequencer for a shared AND-type clock gate: arbitrates wake requests, applies a
// settle delay before granting, an idle hysteresis before gating, and test-enable pass-through.
module clk_gate_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int THR_W       = 8
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               busy_i,
  input  logic               force_on_i,
  input  logic               test_mode_i,
  input  logic [THR_W-1:0]   idle_thr_i,
  output logic               en_o,
  output logic               te_o,
  output logic [NUM_REQ-1:0] ack_o,
  output logic [1:0]         state_o,
  output logic [15:0]        gate_cnt_o
);

  localparam int WC_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WC_W-1:0] WAKE_INIT = WC_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    WAKE  = 2'b01,
    ON    = 2'b10,
    DRAIN = 2'b11
  } state_t;

  state_t            state_q;
  logic [WC_W-1:0]   wake_cnt_q;
  logic [THR_W-1:0]  idle_cnt_q;
  logic [15:0]       gate_cnt_q;
  logic              en_q;
  logic              activity;

  assign activity = (|req_i) | busy_i | force_on_i;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= OFF;
      wake_cnt_q <= '0;
      idle_cnt_q <= '0;
      gate_cnt_q <= '0;
    end else begin
      case (state_q)
        OFF: begin
          if (activity) begin
            state_q    <= WAKE;
            wake_cnt_q <= WAKE_INIT;
          end
        end
        WAKE: begin
          // Requests dropping here do not abort the settle delay.
          if (wake_cnt_q == '0) state_q <= ON;
          else                  wake_cnt_q <= wake_cnt_q - WC_W'(1);
        end
        ON: begin
          if (!activity) begin
            if (idle_thr_i == '0) begin
              state_q    <= OFF;
              gate_cnt_q <= sat_inc(gate_cnt_q);
            end else begin
              state_q    <= DRAIN;
              idle_cnt_q <= idle_thr_i - THR_W'(1);
            end
          end
        end
        DRAIN: begin
          // Activity beats an expiring idle count: no gating that cycle.
          if (activity) begin
            state_q <= ON;
          end else if (idle_cnt_q == '0) begin
            state_q    <= OFF;
            gate_cnt_q <= sat_inc(gate_cnt_q);
          end else begin
            idle_cnt_q <= idle_cnt_q - THR_W'(1);
          end
        end
        default: state_q <= OFF;
      endcase
    end
  end

  // The gate has no latch, so its enable may only change while clk_i is low.
  always_ff @(negedge clk_i or negedge arst_ni) begin
    if (!arst_ni) en_q <= 1'b0;
    else          en_q <= (state_q != OFF);
  end

  assign en_o       = en_q;
  assign te_o       = test_mode_i;
  assign ack_o      = req_i & {NUM_REQ{state_q == ON}};
  assign state_o    = state_q;
  assign gate_cnt_o = gate_cnt_q;

endmodule
